// File: rtl/spi_rw_pkg.sv
// spi_rw_pkg: shared types and constants for the SPI read/write demo
package spi_rw_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_DONE} mst_state_e;
  typedef enum logic {SL_CMD, SL_DATA} slv_state_e;
  localparam int   FRAME_BITS = 17;
  localparam logic CMD_WRITE  = 1'b1;
  localparam logic CMD_READ   = 1'b0;
endpackage

// File: rtl/spi_rw_top_slave.sv
// spi_slave_reg: SPI mode-0 slave holding one DATA_W-bit storage register
//   clk  in  system clock         rst  in  async active-low reset
//   CS   in  chip select (low)    SCLK in  serial clock from master
//   SDO  in  master-out data      SDI  out master-in data (0 while CS=1)
module spi_slave_reg
  import spi_rw_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic CS,
  input  logic SCLK,
  input  logic SDO,
  output logic SDI
);
  slv_state_e        r_state;
  logic              r_sclk_q;
  logic              r_cmd;
  logic              r_sdi;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_store;
  logic              w_rise;
  logic              w_fall;
  // SCLK is oversampled by clk; edges are seen one cycle after SCLK changes
  assign w_rise = SCLK & ~r_sclk_q;
  assign w_fall = ~SCLK & r_sclk_q;
  assign SDI    = CS ? 1'b0 : r_sdi;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= SL_CMD;
      r_sclk_q <= 1'b0;
      r_cmd    <= 1'b0;
      r_sdi    <= 1'b0;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_store  <= '0;
    end else begin
      r_sclk_q <= SCLK;
      if (CS) begin
        r_state <= SL_CMD;
        r_cmd   <= 1'b0;
        r_sdi   <= 1'b0;
        r_cnt   <= '0;
        r_sh    <= '0;
      end else if (w_rise) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_state == SL_CMD) begin
          // preload storage so a read can start shifting on the next fall
          r_state <= SL_DATA;
          r_cmd   <= SDO;
          r_sh    <= r_store;
        end else if (r_cmd == CMD_WRITE) begin
          r_sh <= {r_sh[DATA_W-2:0], SDO};
          // commit only on the last bit so partial frames leave storage intact
          if (r_cnt == 5'(FRAME_BITS - 1)) r_store <= {r_sh[DATA_W-2:0], SDO};
        end
      end else if (w_fall && r_state == SL_DATA && r_cmd == CMD_READ) begin
        r_sdi <= r_sh[DATA_W-1];
        r_sh  <= r_sh << 1;
      end
    end
  end
endmodule

// File: rtl/spi_rw_top.sv
// spi_rw_top: button-driven SPI master writing/reading an internal SPI slave register
//   clk    in  system clock            rst    in  async active-low reset
//   sw     in  write payload           rd_btn in  read request (rising edge)
//   wr_btn in  write request (rising)  led    out last value read back
module spi_rw_top
  import spi_rw_pkg::*;
#(
  parameter int SCLK_HALF = 2,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              rd_btn,
  input  logic              wr_btn,
  output logic [DATA_W-1:0] led
);
  localparam int            HW     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_HALF - 1);
  mst_state_e        r_state;
  logic              CS, SCLK, SDO, SDI, rd, wr, done;
  logic              r_rd_s, r_rd_p, r_wr_s, r_wr_p;
  logic [HW-1:0]     r_hcnt;
  logic [4:0]        r_bits;
  logic [DATA_W:0]   r_tx;
  logic [DATA_W-1:0] r_rx;
  logic              w_idle, w_wr_start, w_rd_start, w_half_end;
  assign w_idle     = r_state == ST_IDLE;
  assign w_wr_start = w_idle & r_wr_s & ~r_wr_p;
  assign w_rd_start = w_idle & r_rd_s & ~r_rd_p;
  assign w_half_end = r_hcnt == H_LAST;
  assign CS         = w_idle | (r_state == ST_DONE);
  assign SDO        = r_tx[DATA_W];
  assign done       = r_state == ST_DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rd_s  <= 1'b0;
      r_rd_p  <= 1'b0;
      r_wr_s  <= 1'b0;
      r_wr_p  <= 1'b0;
      r_hcnt  <= '0;
      r_bits  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      SCLK    <= 1'b0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      led     <= '0;
    end else begin
      r_rd_s <= rd_btn;
      r_rd_p <= r_rd_s;
      r_wr_s <= wr_btn;
      r_wr_p <= r_wr_s;
      case (r_state)
        ST_IDLE: if (w_wr_start | w_rd_start) begin
          // write wins when both buttons rise together
          r_state <= ST_SETUP;
          r_hcnt  <= '0;
          r_bits  <= '0;
          wr      <= w_wr_start;
          rd      <= ~w_wr_start;
          r_tx    <= w_wr_start ? {CMD_WRITE, sw} : {CMD_READ, {DATA_W{1'b0}}};
        end
        ST_SETUP: if (w_half_end) begin
          r_state <= ST_SHIFT;
          r_hcnt  <= '0;
          SCLK    <= 1'b1;
        end else r_hcnt <= r_hcnt + 1'b1;
        ST_SHIFT: begin
          // sample SDI at the same point the slave sees the rising edge
          if (SCLK && r_hcnt == '0) r_rx <= {r_rx[DATA_W-2:0], SDI};
          if (!w_half_end) r_hcnt <= r_hcnt + 1'b1;
          else begin
            r_hcnt <= '0;
            if (SCLK) begin
              SCLK   <= 1'b0;
              r_tx   <= r_tx << 1;
              r_bits <= r_bits + 5'd1;
            end else if (r_bits == 5'(FRAME_BITS)) r_state <= ST_HOLD;
            else SCLK <= 1'b1;
          end
        end
        ST_HOLD: if (w_half_end) begin
          // led is loaded on entry so it is already valid in the done cycle
          r_state <= ST_DONE;
          if (rd) led <= r_rx;
        end else r_hcnt <= r_hcnt + 1'b1;
        ST_DONE: begin
          r_state <= ST_IDLE;
          rd      <= 1'b0;
          wr      <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  spi_slave_reg #(.DATA_W(DATA_W)) u_slave (
    .clk (clk),
    .rst (rst),
    .CS  (CS),
    .SCLK(SCLK),
    .SDO (SDO),
    .SDI (SDI)
  );
endmodule

// File: tb/tb_spi_rw_top.sv
// tb_spi_rw_top: directed self-checking bench for spi_rw_top
module tb_spi_rw_top;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_btn = 1'b0;
  logic        wr_btn = 1'b0;
  logic [15:0] sw = '0;
  logic [15:0] led;
  int n_checks = 0, n_pass = 0, cs_falls = 0, done_cnt = 0, sclk_edges = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  spi_rw_top dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .rd_btn(rd_btn),
    .wr_btn(wr_btn),
    .led   (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_cs && !dut.CS) cs_falls++;
    if (dut.done) done_cnt++;
    if (dut.SCLK !== prev_sclk) sclk_edges++;
    prev_cs   = dut.CS;
    prev_sclk = dut.SCLK;
  end

  task automatic do_frame(input bit is_wr, input logic [15:0] data,
                          output logic [16:0] sdo_bits, output logic [15:0] sdi_bits,
                          output int rises, output int len, output logic [15:0] led_done,
                          output bit got);
    int   t = 0;
    logic ps = 1'b0;
    sdo_bits = '0; sdi_bits = '0; rises = 0; len = 0; led_done = '0; got = 0;
    @(negedge clk);
    if (is_wr) begin sw = data; wr_btn = 1'b1; end
    else rd_btn = 1'b1;
    while (dut.CS === 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (dut.CS === 1'b0) begin
      t = 1;
      while (!got && t < 200) begin
        if (dut.SCLK && !ps) begin
          sdo_bits = {sdo_bits[15:0], dut.SDO};
          sdi_bits = {sdi_bits[14:0], dut.SDI};
          rises++;
        end
        ps = dut.SCLK;
        if (dut.done) begin got = 1; len = t; led_done = led; end
        else begin @(negedge clk); t++; end
      end
    end
    wr_btn = 1'b0;
    rd_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int e0, f0;
    #1 rst = 1'b0;
    sw = 16'hFFFF;
    repeat (5) @(negedge clk);
    n_checks++; if (led !== 16'h0000) $display("FAIL reset_led: got %h want 0000", led); else n_pass++;
    n_checks++; if (dut.CS !== 1'b1) $display("FAIL reset_cs: got %b want 1", dut.CS); else n_pass++;
    n_checks++; if (dut.SCLK !== 1'b0) $display("FAIL reset_sclk: got %b want 0", dut.SCLK); else n_pass++;
    n_checks++; if (dut.done !== 1'b0) $display("FAIL reset_done: got %b want 0", dut.done); else n_pass++;
    n_checks++; if (dut.SDO !== 1'b0) $display("FAIL reset_sdo: got %b want 0", dut.SDO); else n_pass++;
    rst = 1'b1;
    e0 = sclk_edges; f0 = cs_falls;
    repeat (50) @(negedge clk);
    n_checks++; if (sclk_edges - e0 != 0) $display("FAIL idle_sclk: got %0d edges want 0", sclk_edges - e0); else n_pass++;
    n_checks++; if (cs_falls - f0 != 0) $display("FAIL idle_cs: got %0d falls want 0", cs_falls - f0); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [16:0] so; logic [15:0] si, ld; int r, len; bit got;
    do_frame(1'b1, 16'hA5C3, so, si, r, len, ld, got);
    n_checks++; if (!got) $display("FAIL wr_done: got none want pulse"); else n_pass++;
    n_checks++; if (so !== 17'b11010010111000011) $display("FAIL wr_sdo: got %b want 11010010111000011", so); else n_pass++;
    n_checks++; if (r != 17) $display("FAIL wr_rises: got %0d want 17", r); else n_pass++;
    n_checks++; if (len != 73) $display("FAIL wr_len: got %0d want 73", len); else n_pass++;
    n_checks++; if (ld !== 16'h0000) $display("FAIL wr_led: got %h want 0000", ld); else n_pass++;
    n_checks++; if (dut.wr !== 1'b0 || dut.CS !== 1'b1) $display("FAIL wr_after: got wr=%b cs=%b want 0 1", dut.wr, dut.CS); else n_pass++;
    do_frame(1'b0, 16'h0000, so, si, r, len, ld, got);
    n_checks++; if (so[16] !== 1'b0) $display("FAIL rd_cmd: got %b want 0", so[16]); else n_pass++;
    n_checks++; if (si !== 16'hA5C3) $display("FAIL rd_sdi: got %h want a5c3", si); else n_pass++;
    n_checks++; if (ld !== 16'hA5C3) $display("FAIL rd_led_done: got %h want a5c3", ld); else n_pass++;
    n_checks++; if (len != 73) $display("FAIL rd_len: got %0d want 73", len); else n_pass++;
    n_checks++; if (dut.rd !== 1'b0) $display("FAIL rd_after: got %b want 0", dut.rd); else n_pass++;
  endtask

  task automatic test_held();
    logic [16:0] so; logic [15:0] si, ld; int r, len, f0, d0; bit got;
    f0 = cs_falls; d0 = done_cnt;
    @(negedge clk);
    sw = 16'h5A5A; wr_btn = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++; if (cs_falls - f0 != 1) $display("FAIL held_frames: got %0d want 1", cs_falls - f0); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL held_done: got %0d want 1", done_cnt - d0); else n_pass++;
    wr_btn = 1'b0;
    do_frame(1'b0, 16'h0000, so, si, r, len, ld, got);
    n_checks++; if (ld !== 16'h5A5A) $display("FAIL held_read: got %h want 5a5a", ld); else n_pass++;
  endtask

  task automatic test_busy();
    logic [16:0] so; logic [15:0] si, ld; int r, len, f0, d0; bit got;
    f0 = cs_falls; d0 = done_cnt;
    @(negedge clk);
    sw = 16'h0F0F; wr_btn = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (dut.wr !== 1'b1 || dut.CS !== 1'b0) $display("FAIL busy_inframe: got wr=%b cs=%b want 1 0", dut.wr, dut.CS); else n_pass++;
    rd_btn = 1'b1;
    repeat (150) @(negedge clk);
    n_checks++; if (cs_falls - f0 != 1) $display("FAIL busy_frames: got %0d want 1", cs_falls - f0); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL busy_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (led !== 16'h5A5A) $display("FAIL busy_led: got %h want 5a5a", led); else n_pass++;
    rd_btn = 1'b0; wr_btn = 1'b0;
    do_frame(1'b0, 16'h0000, so, si, r, len, ld, got);
    n_checks++; if (ld !== 16'h0F0F) $display("FAIL busy_read: got %h want 0f0f", ld); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [16:0] so; logic [15:0] si, ld; int r, len, t; bit got;
    t = 0;
    @(negedge clk);
    sw = 16'h1234; rd_btn = 1'b1; wr_btn = 1'b1;
    while (dut.CS === 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (dut.wr !== 1'b1 || dut.rd !== 1'b0) $display("FAIL simul_op: got wr=%b rd=%b want 1 0", dut.wr, dut.rd); else n_pass++;
    n_checks++; if (dut.SDO !== 1'b1) $display("FAIL simul_cmd: got %b want 1", dut.SDO); else n_pass++;
    t = 0;
    while (dut.done !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    n_checks++; if (dut.done !== 1'b1) $display("FAIL simul_done: got timeout want pulse"); else n_pass++;
    rd_btn = 1'b0; wr_btn = 1'b0;
    @(negedge clk);
    do_frame(1'b0, 16'h0000, so, si, r, len, ld, got);
    n_checks++; if (ld !== 16'h1234) $display("FAIL simul_read: got %h want 1234", ld); else n_pass++;
  endtask

  task automatic test_abort();
    logic [16:0] so; logic [15:0] si, ld; int r, len, t, e, d0; bit got; logic ps;
    do_frame(1'b1, 16'h00FF, so, si, r, len, ld, got);
    @(negedge clk);
    sw = 16'hFFFF; wr_btn = 1'b1; t = 0;
    while (dut.CS === 1'b1 && t < 20) begin @(negedge clk); t++; end
    ps = dut.SCLK; e = 0; t = 0;
    while (e < 8 && t < 100) begin
      @(negedge clk); t++;
      if (dut.SCLK !== ps) begin e++; ps = dut.SCLK; end
    end
    n_checks++; if (e != 8) $display("FAIL abort_edges: got %0d want 8", e); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (dut.CS !== 1'b1 || dut.SCLK !== 1'b0) $display("FAIL abort_bus: got cs=%b sclk=%b want 1 0", dut.CS, dut.SCLK); else n_pass++;
    n_checks++; if (led !== 16'h0000) $display("FAIL abort_led: got %h want 0000", led); else n_pass++;
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    n_checks++; if (done_cnt != d0) $display("FAIL abort_nodone: got %0d pulses want 0", done_cnt - d0); else n_pass++;
    n_checks++; if (dut.wr !== 1'b0) $display("FAIL abort_wr: got %b want 0", dut.wr); else n_pass++;
    wr_btn = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_frame(1'b0, 16'h0000, so, si, r, len, ld, got);
    n_checks++; if (!got) $display("FAIL abort_read_done: got none want pulse"); else n_pass++;
    n_checks++; if (ld !== 16'h0000) $display("FAIL abort_read: got %h want 0000", ld); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held();
    test_busy();
    test_simultaneous();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
